// File: rtl/clk_en_pkg.sv
// Shared types and constants for the NCO clock-enable generator.
package clk_en_pkg;

    localparam int unsigned ACC_W_DEF = 24;
    localparam int unsigned CH_W_DEF  = 3;

    // Widest accumulator / channel field a configuration record can carry
    localparam int unsigned ACC_W_MAX = 32;
    localparam int unsigned CH_W_MAX  = 3;

    // Pending-slot occupancy
    typedef enum logic {
        SLOT_IDLE    = 1'b0,
        SLOT_PENDING = 1'b1
    } slot_state_e;

    // Configuration record; incr is zero-padded when ACC_W < ACC_W_MAX
    typedef struct packed {
        logic [CH_W_MAX-1:0]  ch;
        logic [ACC_W_MAX-1:0] incr;
        logic                 en;
    } cfg_t;

    // Increment for a 25.175 MHz VGA pixel strobe from the 100 MHz project clock
    localparam longint unsigned PROJECT_CLK_HZ = 64'd100_000_000;
    localparam longint unsigned VGA_PIX_HZ     = 64'd25_175_000;
    localparam logic [ACC_W_DEF-1:0] INCR_VGA_25M175 =
        ACC_W_DEF'((VGA_PIX_HZ << ACC_W_DEF) / PROJECT_CLK_HZ);

endpackage

// File: rtl/clk_en_nco_ch.sv
// One NCO channel: phase accumulator, increment/enable registers and the
// registered carry strobe, plus the rule deciding when a pending update lands.
module clk_en_nco_ch
    import clk_en_pkg::*;
#(
    parameter int unsigned      ACC_W    = ACC_W_DEF,
    parameter logic [ACC_W-1:0] RST_INCR = {1'b1, {(ACC_W-1){1'b0}}},
    parameter logic             RST_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             phase_rst_i,
    input  logic             pend_i,
    input  logic [ACC_W-1:0] pend_incr_i,
    input  logic             pend_en_i,
    output logic             apply_c_o,
    output logic             ce_o,
    output logic             en_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] incr_q, incr_d;
    logic             en_q, en_d;
    logic             ce_q, ce_d;
    logic [ACC_W:0]   sum_c;
    logic             carry_c;

    // Accumulate, decide on applying a pending update, handle phase clear
    always_comb begin
        sum_c     = {1'b0, acc_q} + {1'b0, incr_q};
        carry_c   = en_q & sum_c[ACC_W];
        apply_c_o = pend_i & (~en_q | (incr_q == '0) | carry_c | phase_rst_i);
        acc_d     = en_q ? sum_c[ACC_W-1:0] : '0;
        ce_d      = carry_c;
        incr_d    = incr_q;
        en_d      = en_q;
        if (apply_c_o) begin
            incr_d = pend_incr_i;
            en_d   = pend_en_i;
            // Enabled-to-enabled keeps the wrapped remainder for phase continuity
            if (!en_q || !pend_en_i) begin
                acc_d = '0;
            end
        end
        if (phase_rst_i) begin
            acc_d = '0;
            ce_d  = 1'b0;
        end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            incr_q <= RST_INCR;
            en_q   <= RST_EN;
            ce_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            incr_q <= incr_d;
            en_q   <= en_d;
            ce_q   <= ce_d;
        end
    end

    assign ce_o = ce_q;
    assign en_o = en_q;

endmodule

// File: rtl/clk_en_nco.sv
// Multi-channel NCO clock-enable generator with a single-slot, handshaked,
// phase-continuous configuration path.
module clk_en_nco
    import clk_en_pkg::*;
#(
    parameter int unsigned      N_CH     = 2,
    parameter int unsigned      ACC_W    = ACC_W_DEF,
    parameter int unsigned      CH_W     = CH_W_DEF,
    parameter logic [ACC_W-1:0] RST_INCR = {1'b1, {(ACC_W-1){1'b0}}},
    parameter logic             RST_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [ACC_W-1:0] cfg_incr,
    input  logic             cfg_en,
    input  logic             phase_rst,
    output logic [N_CH-1:0]  ce,
    output logic [N_CH-1:0]  ch_en,
    output logic             cfg_err
);

    slot_state_e     state_q, state_d;
    cfg_t            slot_q, slot_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic [N_CH-1:0] pend_c;
    logic [N_CH-1:0] apply_c;
    logic            unused_slot_bits;

    // Slot FSM: accept into the empty slot, release once the target channel applies
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        err_d   = 1'b0;
        case (state_q)
            SLOT_IDLE: begin
                if (cfg_valid) begin
                    if (32'(cfg_ch) < N_CH) begin
                        slot_d.ch   = CH_W_MAX'(cfg_ch);
                        slot_d.incr = ACC_W_MAX'(cfg_incr);
                        slot_d.en   = cfg_en;
                        state_d     = SLOT_PENDING;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SLOT_PENDING: begin
                if (|apply_c) begin
                    state_d = SLOT_IDLE;
                end
            end
            default: state_d = SLOT_IDLE;
        endcase
        ready_d = (state_d == SLOT_IDLE);
    end

    // Slot and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_IDLE;
            slot_q  <= '0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_err   = err_q;

    // Padding bits of the stored increment are never consumed
    assign unused_slot_bits = ^slot_q.incr;

    // Channel decode and per-channel NCOs
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign pend_c[i] = (state_q == SLOT_PENDING) && (slot_q.ch == CH_W_MAX'(i));

        clk_en_nco_ch #(
            .ACC_W    (ACC_W),
            .RST_INCR (RST_INCR),
            .RST_EN   (RST_EN)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .phase_rst_i (phase_rst),
            .pend_i      (pend_c[i]),
            .pend_incr_i (ACC_W'(slot_q.incr)),
            .pend_en_i   (slot_q.en),
            .apply_c_o   (apply_c[i]),
            .ce_o        (ce[i]),
            .en_o        (ch_en[i])
        );
    end

endmodule
